// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 clock,
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop) and reports codes or errors.
module ps2_receiver #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2_clk,
   input  logic       PS2_data,
   output logic [7:0] code_out,
   output logic       code_valid,
   output logic       frame_err,
   output logic       busy
);

   // state    | meaning
   // S_IDLE   | waiting for a start bit (data low on a filtered falling edge)
   // S_DATA   | shifting in 8 data bits, LSB first
   // S_PARITY | capturing the odd-parity bit
   // S_STOP   | checking stop bit and parity, then publishing code or error
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   logic          clk_s1_q, clk_s2_q;
   logic          dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          timed_out;
   logic          parity_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= FILT_LOAD;
      end else begin
         clk_s1_q   <= PS2_clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= PS2_data;
         dat_s2_q   <= dat_s1_q;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // Down-counter reloads whenever the synchronized clock agrees with the filtered one,
   // so only an unbroken run of FILTER_LEN differing samples reaches terminal count.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = FILT_LOAD;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == '0) begin
            filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q - FW'(1);
         end
      end
   end

   assign fall      = filt_q & ~filt_d;
   assign parity_ok = ^{shift_q, par_q};
   assign timed_out = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (fall && !dat_s2_q) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_d = S_IDLE;
               if (dat_s2_q && parity_ok) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // timed_out excludes edge cycles, so it never collides with a stop-bit result
      if (timed_out) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
      end
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign frame_err  = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized PS/2 frames checked against a frame-level reference model.
module tb_ps2_receiver;
   localparam int FL   = 8;
   localparam int TO   = 2000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       PS2_clk = 1'b1;
   logic       PS2_data = 1'b1;
   logic [7:0] code_out;
   logic       code_valid;
   logic       frame_err;
   logic       busy;

   ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .PS2_clk    (PS2_clk),
      .PS2_data   (PS2_data),
      .code_out   (code_out),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0, n_bad = 0;
   int   n_valid = 0, n_err = 0, n_busy = 0, n_both = 0, n_double = 0;
   int   last_valid_cyc = 0, last_err_cyc = 0;
   logic prev_v = 1'b0, prev_e = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         prev_v = 1'b0;
         prev_e = 1'b0;
      end else begin
         if (code_valid) begin n_valid++; last_valid_cyc = cyc; end
         if (frame_err)  begin n_err++;   last_err_cyc   = cyc; end
         if (code_valid && frame_err) n_both++;
         if ((code_valid && prev_v) || (frame_err && prev_e)) n_double++;
         if (busy) n_busy++;
         prev_v = code_valid;
         prev_e = frame_err;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int fall_cyc = 0;

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         PS2_data = bits[i];
         wait_cyc(HALF);
         PS2_clk  = 1'b0;
         fall_cyc = cyc;
         wait_cyc(HALF);
         PS2_clk  = 1'b1;
      end
      PS2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
      return {stp, par, d, 1'b0};
   endfunction

   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   logic [7:0] model_code = 8'h00;

   task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stp);
      int   v0, e0, lat;
      logic good;
      v0   = n_valid;
      e0   = n_err;
      good = ((($countones(d) + int'(par)) % 2) == 1) && stp;
      if (good) model_code = d;
      send_bits(mk_frame(d, par, stp), 11);
      wait_cyc(2);
      lat = good ? (last_valid_cyc - fall_cyc) : (last_err_cyc - fall_cyc);
      check({tag, " code_out"}, code_out, model_code);
      check({tag, " valid_pulses"}, n_valid - v0, good ? 1 : 0);
      check({tag, " err_pulses"}, n_err - e0, good ? 0 : 1);
      check({tag, " latency_ok"}, (lat >= 9 && lat <= 12), 1);
      check({tag, " busy"}, busy, 0);
   endtask

   initial begin
      int         v0, e0, b0, lat, r;
      logic [7:0] d;
      logic       par, stp;

      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(1);
      check("rst code_out", code_out, 8'h00);
      check("rst valid", code_valid, 0);
      check("rst err", frame_err, 0);
      check("rst busy", busy, 0);

      run_frame("1c_good", 8'h1C, 1'b0, 1'b1);
      run_frame("1c_badpar", 8'h1C, 1'b1, 1'b1);
      run_frame("f0_badstop", 8'hF0, 1'b1, 1'b0);
      run_frame("f0_good", 8'hF0, 1'b1, 1'b1);

      // short low glitches on the PS/2 clock while data sits at start-bit level
      v0 = n_valid; e0 = n_err; b0 = n_busy;
      PS2_data = 1'b0;
      PS2_clk  = 1'b0; wait_cyc(3); PS2_clk = 1'b1; wait_cyc(30);
      PS2_clk  = 1'b0; wait_cyc(7); PS2_clk = 1'b1; wait_cyc(30);
      PS2_data = 1'b1;
      check("glitch busy_cycles", n_busy - b0, 0);
      check("glitch valid", n_valid - v0, 0);
      check("glitch err", n_err - e0, 0);
      check("glitch code_out", code_out, model_code);

      // abandoned frame: start plus four data bits, then silence
      v0 = n_valid; e0 = n_err;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
      wait_cyc(TO / 2);
      check("timeout busy_mid", busy, 1);
      wait_cyc(TO / 2 + 60);
      lat = last_err_cyc - fall_cyc;
      check("timeout err", n_err - e0, 1);
      check("timeout valid", n_valid - v0, 0);
      check("timeout delay_ok", (lat >= TO + 8 && lat <= TO + 13), 1);
      check("timeout busy", busy, 0);
      run_frame("after_timeout", 8'h1C, 1'b0, 1'b1);

      // reset in the middle of a frame
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 6);
      wait_cyc(5);
      check("midrst busy_before", busy, 1);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      model_code = 8'h00;
      e0 = n_err;
      wait_cyc(50);
      check("midrst code_out", code_out, 8'h00);
      check("midrst busy", busy, 0);
      check("midrst err", n_err - e0, 0);
      run_frame("after_reset", 8'h1C, 1'b0, 1'b1);

      for (int k = 0; k < 12; k++) begin
         d   = 8'($urandom);
         r   = int'($urandom_range(0, 3));
         par = odd_par(d);
         if (r == 1) par = ~par;
         stp = (r == 2) ? 1'b0 : 1'b1;
         run_frame("rand", d, par, stp);
      end

      check("never_both", n_both, 0);
      check("never_double", n_double, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 The block SHALL have one clock and reset SHALL be synchronous and active-high.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal synchronized samples of ps2_clk required before the filtered clock changes.
REQ-003 Parameter TIMEOUT, default 100000: clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 PS2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-007 PS2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-008 code_out  output  8  last correctly received scan code.
REQ-009 code_valid  output  1  one-cycle pulse: code_out was just updated.
REQ-010 frame_err  output  1  one-cycle pulse: frame rejected (parity, stop or timeout).
REQ-011 busy  output  1  high while state is not IDLE.

Function
REQ-012 PS2_clk and PS2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered clock SHALL take the synchronized PS2_clk value only after FILTER_LEN consecutive clk samples equal to that value and different from the current filtered value; shorter pulses are ignored.
REQ-014 A falling edge SHALL be the single cycle in which the filtered clock goes 1->0; synchronized PS2_data is sampled in that cycle.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on a falling edge with data=0 (start bit), go to DATA with bit counter=0; with data=1, stay in IDLE with no output pulse.
REQ-017 DATA: on each falling edge, shift the sampled bit into an 8-bit shift register LSB first and increment a 3-bit counter; after the 8th bit (counter wraps 7->0), go to PARITY.
REQ-018 PARITY: on a falling edge, store the bit; parity is good when the XOR of 8 data bits and the parity bit = 1 (odd parity); go to STOP.
REQ-019 STOP: on a falling edge, return to IDLE; if stop bit=1 and parity good, load code_out with the shift register and pulse code_valid in the next cycle; otherwise pulse frame_err in the next cycle and hold code_out.
REQ-020 Latency: code_valid/frame_err SHALL assert exactly one clk cycle after the stop-bit falling-edge cycle.
REQ-021 A timeout counter SHALL clear on every falling edge and in IDLE and count otherwise; on reaching TIMEOUT in DATA, PARITY or STOP, the FSM SHALL return to IDLE and pulse frame_err in the next cycle.
REQ-022 code_valid and frame_err SHALL never be high in the same cycle, and neither SHALL be high for more than one cycle per frame.
REQ-023 Back-to-back frames SHALL be accepted with no dead time beyond the return to IDLE.
REQ-024 busy SHALL be high in DATA, PARITY and STOP, and low in IDLE.

Reset
REQ-025 Reset SHALL force the following: state=IDLE, code_out=8'h00, code_valid=0, frame_err=0, shift register=0, bit counter=0, timeout counter=0, synchronizer flops and filtered clock=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse; reset SHALL take priority over all other events in the same cycle.

Verification
REQ-027 Frame start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1 (PS2_clk period 2000 clk cycles) -> code_out=8'h1C, one code_valid pulse, frame_err never high.
REQ-028 Same frame with parity 1 -> one frame_err pulse, code_valid stays 0, code_out keeps its previous value.
REQ-029 Valid 8'hF0 frame (data 0,0,0,0,1,1,1,1, parity 1) with stop bit 0 -> frame_err pulse, code_out unchanged; then a correct 8'hF0 frame -> code_out=8'hF0 and a code_valid pulse.
REQ-030 In IDLE, 3-cycle and 7-cycle low glitches on PS2_clk with PS2_data=0 -> no state change, busy stays 0, no output pulses.
REQ-031 Start bit plus 4 data bits, then PS2_clk held high -> frame_err pulse TIMEOUT(+pipeline) cycles after the last edge, busy drops; then a correct 8'h1C frame is received.
REQ-032 Reset asserted after the 5th data bit, then a correct 8'h1C frame -> no frame_err pulse, code_out=8'h00 until the new frame, then 8'h1C with a code_valid pulse.
